// File: rtl/mem_copy_engine.sv
// Memory-to-memory copy engine.
// Copies Length words from SrcBase to DstBase through a single-port data
// memory that forms base+offset itself. Each word costs one READ cycle
// (load data captured into a hold register) and one WRITE cycle (store).
// Copies proceed in ascending order, so an overlapping destination above
// the source replicates source data.
module mem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcBase,
  input  logic [A-1:0] DstBase,
  input  logic [A-1:0] Length,
  output logic [A-1:0] MemAddress,
  output logic [A-1:0] MemOffset,
  output logic         MemWriteEn,
  output logic [W-1:0] MemWData,
  input  logic [W-1:0] MemRData,
  output logic         Busy,
  output logic         Done,
  output logic [A-1:0] Count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [A-1:0] src;
  logic [A-1:0] dst;
  logic [A-1:0] len;
  logic [A-1:0] idx;
  logic [A-1:0] count;
  logic [W-1:0] hold;
  logic [A-1:0] idx_next;

  assign idx_next = idx + 1'b1;

  // Copy sequencing: latch the request, then alternate READ/WRITE per word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      idx   <= '0;
      count <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src   <= SrcBase;
            dst   <= DstBase;
            len   <= Length;
            idx   <= '0;
            count <= '0;
            state <= (Length != '0) ? READ : DONE;
          end
        end
        READ: begin
          hold  <= MemRData;
          state <= WRITE;
        end
        WRITE: begin
          idx   <= idx_next;
          count <= count + 1'b1;
          state <= (idx_next == len) ? DONE : READ;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port and status outputs decoded from the current state only.
  always_comb begin
    MemAddress = '0;
    MemOffset  = '0;
    MemWriteEn = 1'b0;
    MemWData   = '0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      READ: begin
        MemAddress = src;
        MemOffset  = idx;
        Busy       = 1'b1;
      end
      WRITE: begin
        MemAddress = dst;
        MemOffset  = idx;
        MemWData   = hold;
        MemWriteEn = 1'b1;
        Busy       = 1'b1;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign Count = count;

endmodule
